// File: rtl/add_pipe_if.sv
// Operand/result handshake bundle for add_pipe.
// The slave modport is the adder itself; the master modport is everything around it
// (the producer of operand beats and the consumer of result beats).
interface add_pipe_if #(
  parameter int unsigned WIDTH = 48
);

  // Operand side
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_data_one;
  logic [WIDTH-1:0] i_data_two;
  logic             i_carry;
  logic             i_sub;

  // Result side
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_data;
  logic             o_carry;
  logic             o_overflow;

  modport slave (
    input  i_valid,
    input  i_data_one,
    input  i_data_two,
    input  i_carry,
    input  i_sub,
    input  i_ready,
    output o_ready,
    output o_valid,
    output o_data,
    output o_carry,
    output o_overflow
  );

  modport master (
    output i_valid,
    output i_data_one,
    output i_data_two,
    output i_carry,
    output i_sub,
    output i_ready,
    input  o_ready,
    input  o_valid,
    input  o_data,
    input  o_carry,
    input  o_overflow
  );

endinterface

// File: rtl/add_pipe.sv
// Pipelined ripple-carry adder/subtractor.
// The carry chain is cut into STAGES equal slices. Each stage register carries the
// full operand pair (upper slices act as input skew), the partial result (lower
// slices act as output deskew), the slice carry-out and a valid bit. A single global
// enable freezes every stage, bubbles included, while the output is stalled.
module add_pipe #(
  parameter int unsigned WIDTH  = 48,
  parameter int unsigned STAGES = 4
) (
  input logic      i_clk,
  input logic      i_rst,
  add_pipe_if.slave bus
);

  localparam int unsigned SEG = WIDTH / STAGES;

  if ((STAGES == 0) || (WIDTH < STAGES) || ((WIDTH % STAGES) != 0)) begin : gen_param_check
    $error("add_pipe: WIDTH must be a non-zero multiple of STAGES");
  end

  // Stage registers
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];  // already inverted for subtract
  logic [WIDTH-1:0]  r_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;
  logic              ov_q;

  // Next-state values
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  r_d [STAGES];
  logic [STAGES-1:0] c_d;
  logic [STAGES-1:0] v_d;
  logic              ov_d;
  logic [SEG:0]      seg_sum;
  logic              cin0;
  logic              adv;

  // Global advance: the pipeline moves unless a held result is being refused.
  always_comb begin
    adv         = ~v_q[STAGES-1] | bus.i_ready;
    bus.o_ready = adv & ~i_rst;
  end

  assign bus.o_valid    = v_q[STAGES-1];
  assign bus.o_data     = r_q[STAGES-1];
  assign bus.o_carry    = c_q[STAGES-1];
  assign bus.o_overflow = ov_q;

  // Per-stage slice addition; stage 0 consumes the raw inputs, later stages their predecessor.
  always_comb begin
    a_d[0]  = bus.i_data_one;
    b_d[0]  = bus.i_sub ? ~bus.i_data_two : bus.i_data_two;
    // Subtract uses the inverted borrow as carry-in: A + ~B + ~bin == A - B - bin.
    cin0    = bus.i_carry ^ bus.i_sub;
    seg_sum = {1'b0, a_d[0][SEG-1:0]} + {1'b0, b_d[0][SEG-1:0]} + {{SEG{1'b0}}, cin0};
    r_d[0]  = '0;
    r_d[0][SEG-1:0] = seg_sum[SEG-1:0];
    c_d[0]  = seg_sum[SEG];
    v_d[0]  = bus.i_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_d[k]  = a_q[k-1];
      b_d[k]  = b_q[k-1];
      r_d[k]  = r_q[k-1];
      v_d[k]  = v_q[k-1];
      seg_sum = {1'b0, a_q[k-1][k*SEG +: SEG]} + {1'b0, b_q[k-1][k*SEG +: SEG]}
                + {{SEG{1'b0}}, c_q[k-1]};
      r_d[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
      c_d[k]  = seg_sum[SEG];
    end
    // Overflow needs only the operand and result sign bits once the top slice is known.
    ov_d = (a_d[STAGES-1][WIDTH-1] == b_d[STAGES-1][WIDTH-1]) &
           (r_d[STAGES-1][WIDTH-1] != a_d[STAGES-1][WIDTH-1]);
  end

  // Stage registers: valid bits always advance with adv; payload loads only for real beats,
  // so the output fields keep their last value across bubbles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end
      c_q  <= '0;
      v_q  <= '0;
      ov_q <= 1'b0;
    end else if (adv) begin
      v_q <= v_d;
      for (int k = 0; k < STAGES; k++) begin
        if (v_d[k]) begin
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
          r_q[k] <= r_d[k];
          c_q[k] <= c_d[k];
        end
      end
      if (v_d[STAGES-1]) begin
        ov_q <= ov_d;
      end
    end
  end

endmodule

// File: tb/tb_add_pipe.sv
// Scoreboard bench for add_pipe: a 48-bit/4-stage instance and an 8-bit/1-stage instance
// share clock, reset, handshake controls and (truncated) operands. Each instance has its own
// expected-result queue fed on acceptance and drained by its own output monitor.
module tb_add_pipe;

  localparam int LAT_A = 4;
  localparam int LAT_B = 1;

  logic clk;
  logic rst;

  add_pipe_if #(.WIDTH(48)) bif ();
  add_pipe_if #(.WIDTH(8))  sif ();

  add_pipe #(.WIDTH(48), .STAGES(4)) u_dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bif)
  );

  add_pipe #(.WIDTH(8), .STAGES(1)) u_dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (sif)
  );

  assign sif.i_valid    = bif.i_valid;
  assign sif.i_data_one = bif.i_data_one[7:0];
  assign sif.i_data_two = bif.i_data_two[7:0];
  assign sif.i_carry    = bif.i_carry;
  assign sif.i_sub      = bif.i_sub;
  assign sif.i_ready    = bif.i_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    bit          c;
    bit          ov;
    int          cyc;
    int          stalls;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  int checks   = 0;
  int failures = 0;
  int cyc_a    = 0;
  int cyc_b    = 0;
  int stalls_a = 0;
  int stalls_b = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on a w-bit two's-complement word.
  function automatic exp_t ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                     input bit cin, input bit sub);
    exp_t        e;
    logic [63:0] mask;
    longint      ua, ub, sa, sb, tot, sres, lim;
    mask = (64'd1 << w) - 64'd1;
    ua   = longint'(a & mask);
    ub   = longint'(b & mask);
    sa   = a[w-1] ? ua - (longint'(1) << w) : ua;
    sb   = b[w-1] ? ub - (longint'(1) << w) : ub;
    if (!sub) begin
      tot  = ua + ub + longint'(cin);
      e.c  = (tot >= (longint'(1) << w));
      sres = sa + sb + longint'(cin);
    end else begin
      tot  = ua - ub - longint'(cin);
      e.c  = (tot >= 0);
      sres = sa - sb - longint'(cin);
    end
    e.d    = 64'(tot) & mask;
    lim    = longint'(1) << (w - 1);
    e.ov   = (sres >= lim) || (sres < -lim);
    e.cyc  = 0;
    e.stalls = 0;
    return e;
  endfunction

  // Monitor for the 48-bit/4-stage instance.
  always @(negedge clk) begin
    if (rst) begin
      q_a.delete();
    end else begin
      if (bif.o_valid && bif.i_ready) begin
        if (q_a.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL a_unexpected_beat actual=%0h required=no_beat", bif.o_data);
        end else begin
          ea = q_a.pop_front();
          chk("a_data", 64'(bif.o_data), ea.d);
          chk("a_carry", 64'(bif.o_carry), 64'(ea.c));
          chk("a_overflow", 64'(bif.o_overflow), 64'(ea.ov));
          chk("a_latency", 64'(cyc_a - ea.cyc), 64'(LAT_A + stalls_a - ea.stalls));
        end
      end
      if (bif.i_valid && bif.o_ready) begin
        ea = ref_model(48, 64'(bif.i_data_one), 64'(bif.i_data_two), bif.i_carry, bif.i_sub);
        ea.cyc    = cyc_a;
        ea.stalls = stalls_a;
        q_a.push_back(ea);
      end
      if (bif.o_valid && !bif.i_ready) stalls_a++;
    end
    cyc_a++;
  end

  // Monitor for the 8-bit/1-stage instance.
  always @(negedge clk) begin
    if (rst) begin
      q_b.delete();
    end else begin
      if (sif.o_valid && sif.i_ready) begin
        if (q_b.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_unexpected_beat actual=%0h required=no_beat", sif.o_data);
        end else begin
          eb = q_b.pop_front();
          chk("b_data", 64'(sif.o_data), eb.d);
          chk("b_carry", 64'(sif.o_carry), 64'(eb.c));
          chk("b_overflow", 64'(sif.o_overflow), 64'(eb.ov));
          chk("b_latency", 64'(cyc_b - eb.cyc), 64'(LAT_B + stalls_b - eb.stalls));
        end
      end
      if (sif.i_valid && sif.o_ready) begin
        eb = ref_model(8, 64'(sif.i_data_one), 64'(sif.i_data_two), sif.i_carry, sif.i_sub);
        eb.cyc    = cyc_b;
        eb.stalls = stalls_b;
        q_b.push_back(eb);
      end
      if (sif.o_valid && !sif.i_ready) stalls_b++;
    end
    cyc_b++;
  end

  function automatic logic [47:0] rnd48();
    logic [63:0] t;
    case ($urandom_range(0, 7))
      0:       t = 64'hFFFF_FFFF_FFFF;
      1:       t = 64'h7FFF_FFFF_FFFF;
      2:       t = 64'h8000_0000_0000;
      default: t = {$urandom(), $urandom()};
    endcase
    return t[47:0];
  endfunction

  task automatic send(input bit v, input logic [47:0] a, input logic [47:0] b,
                      input bit cin, input bit sub);
    bif.i_valid    = v;
    bif.i_data_one = a;
    bif.i_data_two = b;
    bif.i_carry    = cin;
    bif.i_sub      = sub;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 48'h0, 48'h0, 1'b0, 1'b0);
  endtask

  logic [47:0] snap_data;
  logic        snap_carry;
  logic        snap_ovf;

  initial begin
    rst            = 1'b1;
    bif.i_valid    = 1'b0;
    bif.i_data_one = '0;
    bif.i_data_two = '0;
    bif.i_carry    = 1'b0;
    bif.i_sub      = 1'b0;
    bif.i_ready    = 1'b1;

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_a_o_valid", 64'(bif.o_valid), 64'd0);
    chk("rst_a_o_data", 64'(bif.o_data), 64'd0);
    chk("rst_a_o_carry", 64'(bif.o_carry), 64'd0);
    chk("rst_a_o_overflow", 64'(bif.o_overflow), 64'd0);
    chk("rst_a_o_ready", 64'(bif.o_ready), 64'd0);
    chk("rst_b_o_valid", 64'(sif.o_valid), 64'd0);
    chk("rst_b_o_ready", 64'(sif.o_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_a_o_ready", 64'(bif.o_ready), 64'd1);

    // Directed corner beats
    send(1'b1, 48'hFFFF_FFFF_FFFF, 48'h1, 1'b0, 1'b0);
    send(1'b1, 48'h5, 48'h7, 1'b0, 1'b1);
    send(1'b1, 48'h7, 48'h5, 1'b1, 1'b1);
    send(1'b1, 48'h7FFF_FFFF_FFFF, 48'h1, 1'b0, 1'b0);
    send(1'b1, 48'h8000_0000_0000, 48'h1, 1'b0, 1'b1);
    idle(6);

    // Streaming: 8 back-to-back beats, alternating mode
    for (int k = 0; k < 8; k++) send(1'b1, rnd48(), rnd48(), 1'($urandom_range(0, 1)), 1'(k));
    idle(6);

    // Backpressure with a mid-stream bubble
    for (int k = 0; k < 5; k++) send(1'b1, rnd48(), rnd48(), 1'($urandom_range(0, 1)), 1'(k));
    send(1'b0, 48'h0, 48'h0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) send(1'b1, rnd48(), rnd48(), 1'($urandom_range(0, 1)), 1'(k));
    bif.i_ready    = 1'b0;
    bif.i_valid    = 1'b1;
    bif.i_data_one = rnd48();
    bif.i_data_two = rnd48();
    #1;
    snap_data  = bif.o_data;
    snap_carry = bif.o_carry;
    snap_ovf   = bif.o_overflow;
    chk("stall_a_o_valid", 64'(bif.o_valid), 64'd1);
    for (int k = 0; k < 3; k++) begin
      chk("stall_a_o_ready", 64'(bif.o_ready), 64'd0);
      @(posedge clk);
      #1;
      chk("stall_a_o_data_held", 64'(bif.o_data), 64'(snap_data));
      chk("stall_a_o_carry_held", 64'(bif.o_carry), 64'(snap_carry));
      chk("stall_a_o_overflow_held", 64'(bif.o_overflow), 64'(snap_ovf));
      chk("stall_a_o_valid_held", 64'(bif.o_valid), 64'd1);
    end
    bif.i_ready = 1'b1;
    for (int k = 0; k < 3; k++) send(1'b1, rnd48(), rnd48(), 1'($urandom_range(0, 1)), 1'(k));
    idle(8);

    // Reset with three beats in flight
    for (int k = 0; k < 3; k++) send(1'b1, rnd48(), rnd48(), 1'($urandom_range(0, 1)), 1'(k));
    bif.i_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_a_o_ready", 64'(bif.o_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_a_o_valid", 64'(bif.o_valid), 64'd0);
    chk("midrst_b_o_valid", 64'(sif.o_valid), 64'd0);
    idle(6);
    send(1'b1, rnd48(), rnd48(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle(8);

    // Random traffic with random backpressure
    for (int k = 0; k < 300; k++) begin
      bif.i_ready = ($urandom_range(0, 3) != 0);
      send(1'($urandom_range(0, 3) != 0), rnd48(), rnd48(),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Drain, bounded
    bif.i_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (q_a.size() == 0 && q_b.size() == 0) break;
      send(1'b0, 48'h0, 48'h0, 1'b0, 1'b0);
    end
    idle(2);
    chk("drain_a_queue_empty", 64'(q_a.size()), 64'd0);
    chk("drain_b_queue_empty", 64'(q_b.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_pipe.md
Name: add_pipe

Overview:
Parametrised, pipelined ripple-carry adder/subtractor. It is the successor to the fixed 43-bit combinational add chain, generalised in width and carry-pipeline depth, and extended with subtract mode, signed overflow and a valid/ready handshake. It sits in the FP multiplier datapath (exponent and mantissa-product accumulation), where a full-width single-cycle ripple would not meet timing.

Parameters:
- WIDTH, 48, operand and result width in bits; must be ≥ STAGES.
- STAGES, 4, pipeline stages; the carry chain is cut into STAGES equal slices. WIDTH % STAGES != 0 is an elaboration error.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous active-high reset.
- i_valid  input  1  operand beat valid.
- o_ready  output  1  block accepts a beat this cycle.
- i_data_one  input  WIDTH  operand A.
- i_data_two  input  WIDTH  operand B.
- i_carry  input  1  carry-in (add) / borrow-in (sub).
- i_sub  input  1  0: A+B+cin; 1: A−B−bin.
- o_valid  output  1  result beat valid.
- i_ready  input  1  downstream accepts result.
- o_data  output  WIDTH  sum/difference.
- o_carry  output  1  carry-out of MSB (sub: 1 = no borrow).
- o_overflow  output  1  two's-complement signed overflow.

Behaviour:
- Reset is the one clock and synchronous active-high reset: i_clk, i_rst. While i_rst=1 at an edge:
  - All stage valid bits, o_valid, o_data, o_carry and o_overflow go to 0.
  - o_ready=0 during the reset cycle.
  - In-flight beats are discarded; nothing is emitted after reset deasserts.
- Slicing: SEG = WIDTH/STAGES. Stage k (0..STAGES−1) adds slice [k*SEG +: SEG] of A and B' plus the carry registered from stage k−1.
  - Stage 0 takes cin' from the input.
- Sub mode: B' = ~B and cin' = ~i_carry. Add mode: B' = B and cin' = i_carry.
  - i_sub is captured with the beat; mode may change every beat.
- Skew: upper operand slices are delayed in input skew registers until their stage. Lower result slices are delayed in output deskew registers so that all slices of one beat leave together.
- Latency: exactly STAGES cycles from acceptance (i_valid & o_ready) to o_valid for that beat, when there is no stall.
- Throughput: one beat per cycle.
- Handshake: global enable adv = ~o_valid | i_ready; o_ready = adv & ~i_rst.
  - When adv=0, every pipeline register holds, including bubbles. No beat is lost or duplicated.
  - Bubbles are not compressed.
  - A beat is accepted only when i_valid & o_ready. With i_valid=0 and adv=1, a bubble (valid=0) enters.
  - o_data, o_carry and o_overflow stay stable while o_valid=1 & i_ready=0.
  - Output fields are don't-care when o_valid=0; the implementation holds their last value.
- o_carry = carry out of the top slice.
- o_overflow = (A[MSB] == B'[MSB]) & (o_data[MSB] != A[MSB]), evaluated in the top stage.
- Simultaneous accept and emit in one cycle is legal and is the steady state.
- STAGES=1 degenerates to a single registered adder with latency 1.
- Wrap-around: the result is modulo 2^WIDTH; no saturation.

Test Plan (WIDTH=48, STAGES=4 unless noted):
- Full carry ripple: A=0xFFFF_FFFF_FFFF, B=0x1, cin=0, add → 4 cycles later o_data=0x0, o_carry=1, o_overflow=0.
- Subtract with borrow: A=5, B=7, bin=0, sub → o_data=0xFFFF_FFFF_FFFE, o_carry=0. Then A=7, B=5, bin=1 → o_data=1, o_carry=1.
- Signed overflow: A=0x7FFF_FFFF_FFFF, B=1, add → o_data=0x8000_0000_0000, o_overflow=1, o_carry=0.
- Streaming: 8 random back-to-back beats with alternating i_sub and i_ready=1 → o_valid on cycles 4..11, results in order, each matching the reference model.
- Backpressure: pipeline full, i_ready=0 for 3 cycles → o_ready=0 and outputs frozen. After release, the remaining beats emit in order with no duplicates or drops; a mid-stream bubble is preserved.
- Reset mid-stream: 3 beats in flight, i_rst high for 1 cycle → o_valid=0 and no stale beats emerge. A new beat after reset appears exactly 4 cycles later. Repeat the whole scenario with STAGES=1, WIDTH=8 (latency 1).
